date_advance_ctrl: RTL and testbench

Sequential date-advance controller for the calendar datapath. It holds the current date (day, month, year), advances it on a day tick, and validates externally loaded dates. It also serves "date plus N days" queries through a valid/ready handshake. A query steps a one-day increment datapath once per cycle under an FSM, which generalises the combinational day-after-tomorrow lookahead to arbitrary N (N=2 gives day-after-tomorrow) with month-length and year handling.

---
 rtl/date_advance_ctrl_if.sv | 26 ++
 rtl/date_advance_ctrl.sv | 168 ++++++++++++++++
 tb/tb_date_advance_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/date_advance_ctrl_if.sv
// Query/result handshake bundle for the date-advance controller.
// master drives queries and accepts results; slave is the controller.
interface date_advance_ctrl_if #(
    parameter int YEAR_W = 7,
    parameter int STEP_W = 3
);
    logic              q_valid;
    logic              q_ready;
    logic [STEP_W-1:0] q_days;
    logic              r_valid;
    logic              r_ready;
    logic [4:0]        r_day;
    logic [3:0]        r_mon;
    logic [YEAR_W-1:0] r_yr;
    logic              r_err;

    modport master (
        output q_valid, q_days, r_ready,
        input  q_ready, r_valid, r_day, r_mon, r_yr, r_err
    );

    modport slave (
        input  q_valid, q_days, r_ready,
        output q_ready, r_valid, r_day, r_mon, r_yr, r_err
    );
endinterface

// File: rtl/date_advance_ctrl.sv
// Current-date register with tick/load plus a "date + N days" query FSM.
// Define DATE_LEAP_EN to give February 29 days when yr[1:0]==0.
module date_advance_ctrl #(
    parameter int YEAR_W = 7,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_mon,
    input  logic [YEAR_W-1:0] load_yr,
    input  logic              tick,
    output logic [4:0]        cur_day,
    output logic [3:0]        cur_mon,
    output logic [YEAR_W-1:0] cur_yr,
    output logic              err,
    date_advance_ctrl_if.slave qif
);

`ifdef DATE_LEAP_EN
    localparam bit LEAP_EN = 1'b1;
`else
    localparam bit LEAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]        d;
        logic [3:0]        m;
        logic [YEAR_W-1:0] y;
    } date_t;

    typedef struct packed {
        logic  wrap;
        date_t dt;
    } step_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_STEP = 3'b010,
        S_DONE = 3'b100
    } state_t;

    localparam date_t DATE_RST = '{d: 5'd1, m: 4'd1, y: '0};
    localparam logic [YEAR_W-1:0] YR_ONE = {{(YEAR_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] CNT_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    function automatic logic [4:0] mlen(
        input logic [3:0]        m,
        input logic [YEAR_W-1:0] y
    );
        case (m)
            4'd2:    mlen = (LEAP_EN && y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            4'd4,
            4'd6,
            4'd9,
            4'd11:   mlen = 5'd30;
            default: mlen = 5'd31;
        endcase
    endfunction

    function automatic step_t inc(input date_t a);
        inc.dt   = a;
        inc.wrap = 1'b0;
        if (a.d < mlen(a.m, a.y)) begin
            inc.dt.d = a.d + 5'd1;
        end else begin
            inc.dt.d = 5'd1;
            if (a.m == 4'd12) begin
                inc.dt.m = 4'd1;
                inc.dt.y = a.y + YR_ONE;
                inc.wrap = (a.y == '1);
            end else begin
                inc.dt.m = a.m + 4'd1;
            end
        end
    endfunction

    date_t             cur;
    date_t             work;
    logic [STEP_W-1:0] cnt;
    logic              rerr;
    state_t            state;
    state_t            state_nxt;
    step_t             cur_inc;
    step_t             work_inc;
    logic              ld_ok;
    logic              accept;

    always_comb begin
        cur_inc  = inc(cur);
        work_inc = inc(work);
        ld_ok    = (load_mon >= 4'd1) && (load_mon <= 4'd12) &&
                   (load_day != 5'd0) &&
                   (load_day <= mlen(load_mon, load_yr));
        accept   = qif.q_valid && (state == S_IDLE);
    end

    // Load wins over tick; err is sticky until a valid load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= DATE_RST;
            err <= 1'b0;
        end else if (load) begin
            if (ld_ok) begin
                cur <= '{d: load_day, m: load_mon, y: load_yr};
                err <= 1'b0;
            end else begin
                err <= 1'b1;
            end
        end else if (tick) begin
            cur <= cur_inc.dt;
            if (cur_inc.wrap)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (qif.q_valid)
                        state_nxt = (qif.q_days == '0) ? S_DONE : S_STEP;
            S_STEP: if (cnt == CNT_ONE)
                        state_nxt = S_DONE;
            S_DONE: if (qif.r_ready)
                        state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        qif.q_ready = (state == S_IDLE);
        qif.r_valid = (state == S_DONE);
    end

    // Work register snapshots cur before any same-cycle tick/load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= DATE_RST;
            cnt  <= '0;
            rerr <= 1'b0;
        end else if (accept) begin
            work <= cur;
            cnt  <= qif.q_days;
            rerr <= 1'b0;
        end else if (state == S_STEP) begin
            work <= work_inc.dt;
            cnt  <= cnt - CNT_ONE;
            rerr <= rerr | work_inc.wrap;
        end
    end

    assign cur_day   = cur.d;
    assign cur_mon   = cur.m;
    assign cur_yr    = cur.y;
    assign qif.r_day = work.d;
    assign qif.r_mon = work.m;
    assign qif.r_yr  = work.y;
    assign qif.r_err = rerr;

endmodule

// File: tb/tb_date_advance_ctrl.sv
// Bench for date_advance_ctrl: directed cases plus random ops against
// a day-ordinal calendar model (honours DATE_LEAP_EN like the design).
module tb_date_advance_ctrl;
    localparam int YW = 7;
    localparam int SW = 3;
    localparam int NY = 1 << YW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [4:0]    load_day;
    logic [3:0]    load_mon;
    logic [YW-1:0] load_yr;
    logic          tick;
    logic [4:0]    cur_day;
    logic [3:0]    cur_mon;
    logic [YW-1:0] cur_yr;
    logic          err;

    date_advance_ctrl_if #(.YEAR_W(YW), .STEP_W(SW)) qif ();

    date_advance_ctrl #(.YEAR_W(YW), .STEP_W(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_day (load_day),
        .load_mon (load_mon),
        .load_yr  (load_yr),
        .tick     (tick),
        .cur_day  (cur_day),
        .cur_mon  (cur_mon),
        .cur_yr   (cur_yr),
        .err      (err),
        .qif      (qif)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int ord;
    int merr;
    int total;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int leap(input int y);
`ifdef DATE_LEAP_EN
        return (y % 4 == 0) ? 1 : 0;
`else
        return 0 * y;
`endif
    endfunction

    function automatic int mdays(input int m, input int y);
        case (m)
            2:           return 28 + leap(y);
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic int to_ord(input int d, input int m, input int y);
        int o = 0;
        for (int i = 0; i < y; i++) o += 365 + leap(i);
        for (int i = 1; i < m; i++) o += mdays(i, y);
        return o + d - 1;
    endfunction

    task automatic from_ord(input int o, output int d, output int m,
                            output int y);
        y = 0;
        while (o >= 365 + leap(y)) begin
            o -= 365 + leap(y);
            y++;
        end
        m = 1;
        while (o >= mdays(m, y)) begin
            o -= mdays(m, y);
            m++;
        end
        d = o + 1;
    endtask

    task automatic model_tick();
        ord++;
        if (ord == total) begin
            ord  = 0;
            merr = 1;
        end
    endtask

    task automatic check_cur(input string tag);
        int d, m, y;
        from_ord(ord, d, m, y);
        chk({tag, ".cur_day"}, int'(cur_day), d);
        chk({tag, ".cur_mon"}, int'(cur_mon), m);
        chk({tag, ".cur_yr"}, int'(cur_yr), y);
        chk({tag, ".err"}, int'(err), merr);
    endtask

    task automatic do_load(input int d, input int m, input int y);
        load_day = 5'(d);
        load_mon = 4'(m);
        load_yr  = YW'(y);
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (m >= 1 && m <= 12 && d >= 1 && d <= mdays(m, y)) begin
            ord  = to_ord(d, m, y);
            merr = 0;
        end else begin
            merr = 1;
        end
        check_cur("load");
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model_tick();
        check_cur("tick");
    endtask

    task automatic query(input int n, input bit tk, input int hold,
                         output int rd, output int rm, output int ry,
                         output int re);
        int res, ed, em, ey, ee, c;
        bit seen;
        res = ord + n;
        ee  = (res >= total) ? 1 : 0;
        from_ord(res % total, ed, em, ey);
        chk("q_ready_idle", int'(qif.q_ready), 1);
        qif.q_valid = 1'b1;
        qif.q_days  = SW'(n);
        tick        = tk;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                qif.q_valid = 1'b0;
                tick        = 1'b0;
                if (tk) model_tick();
            end
            seen = qif.r_valid;
        end
        chk("latency", c, n + 1);
        chk("r_day", int'(qif.r_day), ed);
        chk("r_mon", int'(qif.r_mon), em);
        chk("r_yr", int'(qif.r_yr), ey);
        chk("r_err", int'(qif.r_err), ee);
        rd = int'(qif.r_day);
        rm = int'(qif.r_mon);
        ry = int'(qif.r_yr);
        re = int'(qif.r_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", int'(qif.r_valid), 1);
            chk("hold_res",
                int'({qif.r_day, qif.r_mon, qif.r_yr, qif.r_err}),
                (ed << (4 + YW + 1)) | (em << (YW + 1)) | (ey << 1) | ee);
        end
        check_cur("query");
        qif.r_ready = 1'b1;
        @(negedge clk);
        qif.r_ready = 1'b0;
        chk("r_valid_drop", int'(qif.r_valid), 0);
        chk("q_ready_back", int'(qif.q_ready), 1);
    endtask

    initial begin
        int rd, rm, ry, re, op, d, m, y;
        rst_n       = 1'b0;
        load        = 1'b0;
        load_day    = '0;
        load_mon    = '0;
        load_yr     = '0;
        tick        = 1'b0;
        qif.q_valid = 1'b0;
        qif.q_days  = '0;
        qif.r_ready = 1'b0;
        total = 0;
        for (int i = 0; i < NY; i++) total += 365 + leap(i);
        ord  = 0;
        merr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_cur("reset");
        chk("rst.q_ready", int'(qif.q_ready), 1);
        chk("rst.r_valid", int'(qif.r_valid), 0);
        chk("rst.r_date", int'({qif.r_day, qif.r_mon, qif.r_yr}),
            (1 << (4 + YW)) | (1 << YW));
        chk("rst.r_err", int'(qif.r_err), 0);

        query(2, 1'b0, 0, rd, rm, ry, re);
        chk("t1.day", rd, 3);
        chk("t1.mon", rm, 1);

        do_load(28, 2, 24);
        query(2, 1'b0, 0, rd, rm, ry, re);
`ifdef DATE_LEAP_EN
        chk("t2.date", rd * 100 + rm, 103);
`else
        chk("t2.date", rd * 100 + rm, 203);
`endif

        do_load(30, 4, 5);
        do_tick();
        chk("t3.tick", int'(cur_day) * 100 + int'(cur_mon), 105);
        do_load(31, 4, 5);
        chk("t3.err", int'(err), 1);
        chk("t3.keep", int'(cur_day) * 100 + int'(cur_mon), 105);

        do_load(31, 12, 127);
        query(2, 1'b0, 0, rd, rm, ry, re);
        chk("t4.res", rd * 10000 + rm * 1000 + ry * 10 + re, 21001);
        do_tick();
        chk("t4.wrap", int'(cur_yr) * 10 + int'(err), 1);

        do_load(28, 1, 1);
        query(7, 1'b1, 5, rd, rm, ry, re);
        chk("t5.res", rd * 10000 + rm * 100 + ry, 40201);
        chk("t5.cur", int'(cur_day), 29);

        qif.q_valid = 1'b1;
        qif.q_days  = SW'(5);
        @(negedge clk);
        qif.q_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        ord  = 0;
        merr = 0;
        check_cur("arst");
        chk("arst.r_valid", int'(qif.r_valid), 0);
        chk("arst.q_ready", int'(qif.q_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                y = int'($urandom_range(0, NY - 1));
                if ($urandom_range(0, 3) == 0) begin
                    m = 12;
                    d = int'($urandom_range(26, 31));
                    y = NY - 1;
                end else begin
                    m = int'($urandom_range(0, 13));
                    d = int'($urandom_range(0, 31));
                end
                do_load(d, m, y);
            end else if (op == 1) begin
                repeat ($urandom_range(1, 3)) do_tick();
            end else begin
                query(int'($urandom_range(0, (1 << SW) - 1)),
                      1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), rd, rm, ry, re);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
